// File: rtl/mem_responder_pkg.sv
// Shared coherence-bus types for the memory-side responder: bus commands,
// request/response messages, pending-request record and responder FSM states.
package mem_responder_pkg;

    localparam int XLEN        = 32;
    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int SRC_W       = 4;
    localparam int MEM_ID      = 15;

    localparam logic [XLEN-1:0] OFFSET_MASK = XLEN'((LINE_BITS / 8) - 1);

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_cmd_t;

    typedef struct packed {
        logic                 valid;
        logic [SRC_W-1:0]     src_id;
        bus_cmd_t             cmd;
        logic [XLEN-1:0]      addr;
        logic [LINE_BITS-1:0] data;
    } req_msg_t;

    typedef struct packed {
        logic                 valid;
        logic [SRC_W-1:0]     src_id;
        logic [SRC_W-1:0]     dst_id;
        logic [XLEN-1:0]      addr;
        logic [LINE_BITS-1:0] data;
    } resp_msg_t;

    typedef struct packed {
        bus_cmd_t             cmd;
        logic [SRC_W-1:0]     src_id;
        logic [XLEN-1:0]      addr;
        logic [LINE_BITS-1:0] data;
    } pend_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_ARB    = 3'd4,
        ST_SEND   = 3'd5
    } state_t;

    function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// In-order pending-request queue: push and pop may coincide; a push while full is dropped.
// Head is visible combinationally on dout while not empty.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: queues bus requests, waits a snoop window for a peer to supply
// the line, else reads memory and sends the response; write-backs go straight to memory.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ID           = MEM_ID,
    parameter int QDEPTH       = 4,
    parameter int SNOOP_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  req_msg_t             req_bus_msg,
    input  resp_msg_t            resp_bus_msg,
    output resp_msg_t            resp_bus_tx,
    output logic                 resp_bus_req,
    input  logic                 resp_bus_gnt,
    output logic                 resp_bus_busy,
    output logic [XLEN-1:0]      dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_BITS-1:0] dfp_wdata,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp,
    output logic                 queue_full
);

    localparam int PEND_W = $bits(pend_t);

    pend_t                   push_ent, head, hold_q, hold_d;
    logic [PEND_W-1:0]       fifo_dout;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(QDEPTH):0] fifo_count;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [LINE_BITS-1:0]    line_q, line_d;
    logic                    overflow_q, overflow_d;
    resp_msg_t               tx_q, tx_d;
    logic                    req_q, req_d, rd_q, rd_d, wr_q, wr_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [LINE_BITS-1:0]    wdata_q, wdata_d;
    logic                    peer_hit;
    logic                    unused_bits;

    assign fifo_push = req_bus_msg.valid && (req_bus_msg.cmd != BUS_UPGR);
    assign push_ent  = '{cmd: req_bus_msg.cmd, src_id: req_bus_msg.src_id,
                         addr: line_addr(req_bus_msg.addr), data: req_bus_msg.data};
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign head      = pend_t'(fifo_dout);

    req_fifo #(
        .WIDTH (PEND_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_ent),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Our own responses carry src_id == ID and must never cancel the held request.
    assign peer_hit = resp_bus_msg.valid && (resp_bus_msg.src_id != SRC_W'(ID)) &&
                      (resp_bus_msg.addr[XLEN-1:OFFSET_BITS] == hold_q.addr[XLEN-1:OFFSET_BITS]);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (fifo_push && fifo_full);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    hold_d = head;
                    if (head.cmd == BUS_WB) begin
                        state_d = ST_MEM_WR;
                    end else begin
                        state_d = ST_SNOOP;
                        cnt_d   = 4'(SNOOP_CYCLES);
                    end
                end
            end
            ST_SNOOP: begin
                cnt_d = cnt_q - 1'b1;
                if (peer_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (dfp_resp) begin
                    line_d  = dfp_rdata;
                    state_d = ST_ARB;
                end
            end
            ST_MEM_WR: begin
                if (dfp_resp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (peer_hit) begin
                    state_d = ST_IDLE;
                end else if (resp_bus_gnt) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        req_d   = (state_d == ST_ARB);
        rd_d    = (state_d == ST_MEM_RD);
        wr_d    = (state_d == ST_MEM_WR);
        addr_d  = (rd_d || wr_d) ? hold_d.addr : '0;
        wdata_d = wr_d ? hold_d.data : '0;
        tx_d    = '0;
        if (state_d == ST_SEND) begin
            tx_d = '{valid: 1'b1, src_id: SRC_W'(ID), dst_id: hold_d.src_id,
                     addr: hold_d.addr, data: line_d};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            tx_q       <= '0;
            req_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            req_q      <= req_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign resp_bus_tx   = tx_q;
    assign resp_bus_busy = tx_q.valid;
    assign resp_bus_req  = req_q;
    assign dfp_read      = rd_q;
    assign dfp_write     = wr_q;
    assign dfp_addr      = addr_q;
    assign dfp_wdata     = wdata_q;
    assign queue_full    = fifo_full;

    assign unused_bits = ^{resp_bus_msg.dst_id, resp_bus_msg.data,
                           resp_bus_msg.addr[OFFSET_BITS-1:0], fifo_count};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of single reads plus hand-written sequences
// for snoop cancel, write-back ordering, overflow, grant stall and mid-read reset.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    req_msg_t             req_bus_msg;
    resp_msg_t            resp_bus_msg;
    resp_msg_t            resp_bus_tx;
    logic                 resp_bus_req;
    logic                 resp_bus_gnt = 1'b0;
    logic                 resp_bus_busy;
    logic [XLEN-1:0]      dfp_addr;
    logic                 dfp_read, dfp_write;
    logic [LINE_BITS-1:0] dfp_wdata;
    logic [LINE_BITS-1:0] dfp_rdata = '0;
    logic                 dfp_resp = 1'b0;
    logic                 queue_full;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_bus_msg   (req_bus_msg),
        .resp_bus_msg  (resp_bus_msg),
        .resp_bus_tx   (resp_bus_tx),
        .resp_bus_req  (resp_bus_req),
        .resp_bus_gnt  (resp_bus_gnt),
        .resp_bus_busy (resp_bus_busy),
        .dfp_addr      (dfp_addr),
        .dfp_read      (dfp_read),
        .dfp_write     (dfp_write),
        .dfp_wdata     (dfp_wdata),
        .dfp_rdata     (dfp_rdata),
        .dfp_resp      (dfp_resp),
        .queue_full    (queue_full)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                         input logic [LINE_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: unwritten lines read as the line address repeated.
    logic [LINE_BITS-1:0] mem [logic [XLEN-1:0]];
    int  mem_lat   = 2;
    bit  mem_stall = 1'b0;
    int  wait_cnt  = 0;
    int  rd_bursts = 0;
    int  op_log[$];
    logic prev_rd = 1'b0, prev_wr = 1'b0;

    function automatic logic [LINE_BITS-1:0] mem_val(input logic [XLEN-1:0] a);
        return mem.exists(a) ? mem[a] : {8{a}};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            dfp_resp = 1'b0;
            wait_cnt = 0;
            prev_rd  = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            if (dfp_read && !prev_rd) begin
                rd_bursts++;
                op_log.push_back(2);
            end
            if (dfp_write && !prev_wr) op_log.push_back(1);
            prev_rd  = dfp_read;
            prev_wr  = dfp_write;
            dfp_resp = 1'b0;
            if ((dfp_read || dfp_write) && !mem_stall) begin
                if (wait_cnt >= mem_lat) begin
                    dfp_resp = 1'b1;
                    wait_cnt = 0;
                    if (dfp_write) mem[dfp_addr] = dfp_wdata;
                    else           dfp_rdata = mem_val(dfp_addr);
                end else begin
                    wait_cnt++;
                end
            end else if (!(dfp_read || dfp_write)) begin
                wait_cnt = 0;
            end
        end
    end

    resp_msg_t seen_q[$];
    int  req_cycles = 0;
    bit  gnt_en     = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            resp_bus_gnt = 1'b0;
        end else begin
            if (resp_bus_tx.valid) begin
                seen_q.push_back(resp_bus_tx);
                check("busy_with_valid", resp_bus_busy, 1'b1);
            end
            if (resp_bus_req) req_cycles++;
            resp_bus_gnt = gnt_en && resp_bus_req;
        end
    end

    task automatic issue(input logic [SRC_W-1:0] src, input bus_cmd_t cmd,
                         input logic [XLEN-1:0] addr, input logic [LINE_BITS-1:0] data);
        req_bus_msg = '{valid: 1'b1, src_id: src, cmd: cmd, addr: addr, data: data};
        @(negedge clk);
        req_bus_msg = '0;
    endtask

    task automatic wait_resps(input string name, input int n, input int budget);
        int k = 0;
        while (seen_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, seen_q.size() >= n, 1'b1);
    endtask

    task automatic wait_read(input string name, input int budget);
        int k = 0;
        while (!dfp_read && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, dfp_read, 1'b1);
    endtask

    typedef struct {
        logic [SRC_W-1:0]     src;
        bus_cmd_t             cmd;
        logic [XLEN-1:0]      addr;
        logic [LINE_BITS-1:0] preload;
        logic [XLEN-1:0]      exp_addr;
        int                   exp_resps;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int rd0, rq0;
        logic [XLEN-1:0]  ov_addr [5];
        logic [SRC_W-1:0] ov_dst  [5];

        vecs[0] = '{4'd2, BUS_RD,   32'h0000_1040, {32{8'hA5}},    32'h0000_1040, 1};
        vecs[1] = '{4'd5, BUS_RDX,  32'h0000_4044, {32{8'h3C}},    32'h0000_4040, 1};
        vecs[2] = '{4'd0, BUS_RD,   32'h5000_001F, {16{16'hBEEF}}, 32'h5000_0000, 1};
        vecs[3] = '{4'd9, BUS_UPGR, 32'h0000_9000, {32{8'h11}},    32'h0000_9000, 0};

        rst          = 1'b0;
        req_bus_msg  = '0;
        resp_bus_msg = '0;
        repeat (3) @(negedge clk);
        check("rst_tx",        resp_bus_tx,   '0);
        check("rst_req",       resp_bus_req,  1'b0);
        check("rst_busy",      resp_bus_busy, 1'b0);
        check("rst_dfp_read",  dfp_read,      1'b0);
        check("rst_dfp_write", dfp_write,     1'b0);
        check("rst_dfp_addr",  dfp_addr,      '0);
        check("rst_full",      queue_full,    1'b0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            mem[vecs[i].exp_addr] = vecs[i].preload;
            seen_q.delete();
            rd0 = rd_bursts;
            issue(vecs[i].src, vecs[i].cmd, vecs[i].addr, '0);
            if (vecs[i].exp_resps > 0) wait_resps($sformatf("vec%0d_resp_wait", i), 1, 60);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_resp_count", i), seen_q.size(), vecs[i].exp_resps);
            check($sformatf("vec%0d_rd_bursts", i), rd_bursts - rd0, vecs[i].exp_resps);
            if (seen_q.size() > 0) begin
                check($sformatf("vec%0d_dst", i),  seen_q[0].dst_id, vecs[i].src);
                check($sformatf("vec%0d_addr", i), seen_q[0].addr,   vecs[i].exp_addr);
                check($sformatf("vec%0d_data", i), seen_q[0].data,   vecs[i].preload);
                check($sformatf("vec%0d_src", i),  seen_q[0].src_id, 4'd15);
            end
        end

        // Peer supplies the line two cycles after the pop.
        seen_q.delete();
        rd0 = rd_bursts;
        rq0 = req_cycles;
        issue(4'd1, BUS_RD, 32'h0000_2000, '0);
        @(negedge clk);
        @(negedge clk);
        resp_bus_msg = '{valid: 1'b1, src_id: 4'd3, dst_id: 4'd1,
                         addr: 32'h0000_2000, data: {32{8'hEE}}};
        @(negedge clk);
        resp_bus_msg = '0;
        repeat (20) @(negedge clk);
        check("peer_no_read",  rd_bursts - rd0,  0);
        check("peer_no_req",   req_cycles - rq0, 0);
        check("peer_no_resp",  seen_q.size(),    0);
        check("peer_idle",     dut.state_q,      ST_IDLE);

        // Write-back followed immediately by a read of the same line.
        seen_q.delete();
        op_log.delete();
        issue(4'd4, BUS_WB, 32'h0000_3000, {32{8'h77}});
        issue(4'd6, BUS_RD, 32'h0000_3000, '0);
        wait_resps("wb_resp_wait", 1, 80);
        repeat (10) @(negedge clk);
        check("wb_resp_count", seen_q.size(), 1);
        check("wb_op_count",   op_log.size(), 2);
        if (op_log.size() >= 2) begin
            check("wb_first_is_write", op_log[0], 1);
            check("wb_then_read",      op_log[1], 2);
        end
        if (seen_q.size() > 0) begin
            check("wb_resp_data", seen_q[0].data,   {32{8'h77}});
            check("wb_resp_dst",  seen_q[0].dst_id, 4'd6);
        end

        // Overflow: responder stalled on a blocker read, then five back-to-back reads.
        mem_stall = 1'b1;
        seen_q.delete();
        issue(4'd7, BUS_RD, 32'h0000_6F00, '0);
        wait_read("ovf_blocker_read", 20);
        ov_addr[0] = 32'h0000_6F00;
        ov_dst[0]  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                ov_addr[i+1] = 32'h0000_6000 + 32'(i * 64);
                ov_dst[i+1]  = 4'(i + 1);
            end
            issue(4'(i + 1), BUS_RD, 32'h0000_6000 + 32'(i * 64), '0);
        end
        check("ovf_queue_full", queue_full,     1'b1);
        check("ovf_flag",       dut.overflow_q, 1'b1);
        mem_stall = 1'b0;
        wait_resps("ovf_resp_wait", 5, 400);
        repeat (40) @(negedge clk);
        check("ovf_resp_count", seen_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (seen_q.size() > i) begin
                check($sformatf("ovf%0d_addr", i), seen_q[i].addr,   ov_addr[i]);
                check($sformatf("ovf%0d_dst", i),  seen_q[i].dst_id, ov_dst[i]);
                check($sformatf("ovf%0d_data", i), seen_q[i].data,   {8{ov_addr[i]}});
            end
        end
        check("ovf_drained", queue_full, 1'b0);

        // Grant withheld for ten cycles.
        gnt_en = 1'b0;
        seen_q.delete();
        issue(4'd3, BUS_RD, 32'h0000_7000, '0);
        begin
            int k = 0;
            while (!resp_bus_req && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        check("gnt_req_raised", resp_bus_req, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("gnt_hold_req%0d", i),  resp_bus_req,      1'b1);
            check($sformatf("gnt_no_valid%0d", i), resp_bus_tx.valid, 1'b0);
        end
        gnt_en = 1'b1;
        wait_resps("gnt_resp_wait", 1, 20);
        repeat (10) @(negedge clk);
        check("gnt_single_send", seen_q.size(), 1);
        if (seen_q.size() > 0) check("gnt_dst", seen_q[0].dst_id, 4'd3);

        // Reset asserted while a read is outstanding with another request queued.
        mem_stall = 1'b1;
        issue(4'd8, BUS_RD, 32'h0000_8000, '0);
        issue(4'd9, BUS_RD, 32'h0000_8040, '0);
        wait_read("rst_mid_read_seen", 20);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_dfp_read", dfp_read,     1'b0);
        check("rst_mid_dfp_addr", dfp_addr,     '0);
        check("rst_mid_req",      resp_bus_req, 1'b0);
        check("rst_mid_tx",       resp_bus_tx,  '0);
        @(negedge clk);
        #2 rst = 1'b1;
        mem_stall = 1'b0;
        @(negedge clk);
        check("rst_mid_fifo_empty", dut.u_fifo.empty, 1'b1);
        check("rst_mid_idle",       dut.state_q,      ST_IDLE);
        check("rst_mid_ovf_clear",  dut.overflow_q,   1'b0);
        seen_q.delete();
        rd0 = rd_bursts;
        repeat (30) @(negedge clk);
        check("rst_mid_no_read", rd_bursts - rd0, 0);
        check("rst_mid_no_resp", seen_q.size(),   0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
